// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: byte steering, load extension, range checks, MMIO port
// Optional feature macro: DATA_MEM_B2B_EN (REQ_READY also high in RESP for back-to-back requests)
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h1100_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  input  logic [31:0] IO_IN,
  output logic [31:0] IO_ADDR,
  output logic [31:0] IO_WDATA,
  output logic        IO_WR
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
`ifdef DATA_MEM_B2B_EN
  localparam logic READY_IN_RESP = 1'b1;
`else
  localparam logic READY_IN_RESP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;
  logic [31:0] rdata_hold;

  // transaction captured at accept
  logic        cap_we, cap_uns, cap_err, cap_mmio;
  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_size;

  logic        accept, req_err, req_mmio, enter_resp, mem_we;
  logic        cur_we, cur_err, cur_mmio;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] src, byte_sh, rdata_now;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept = REQ_VALID & REQ_READY;

  // classify the incoming request: IO region and alignment/size/range errors
  always_comb begin
    req_mmio = (REQ_ADDR >= MMIO_BASE);
    req_err  = 1'b0;
    case (REQ_SIZE)
      2'b01:   req_err = REQ_ADDR[0];
      2'b10:   req_err = (REQ_ADDR[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (!req_mmio && ((REQ_ADDR >> (ADDR_WIDTH + 2)) != 32'd0)) req_err = 1'b1;
  end

  // the transaction in flight: the incoming one on an accept edge, else the captured one
  always_comb begin
    cur_we    = accept ? REQ_WE    : cap_we;
    cur_err   = accept ? req_err   : cap_err;
    cur_mmio  = accept ? req_mmio  : cap_mmio;
    cur_addr  = accept ? REQ_ADDR  : cap_addr;
    cur_wdata = accept ? REQ_WDATA : cap_wdata;
    cur_size  = accept ? REQ_SIZE  : cap_size;
    cur_idx   = cur_addr[ADDR_WIDTH+1:2];
    if (accept) enter_resp = (WS == 4'd0) || req_err;
    else        enter_resp = (state == WAIT) && (cnt == 4'd1);
    mem_we = enter_resp && cur_we && !cur_err && !cur_mmio;
  end

  // store lane steering: replicate the right-aligned data and enable only the addressed lanes
  always_comb begin
    be = 4'b0000;
    wd = cur_wdata;
    case (cur_size)
      2'b00: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // storage: write commits on the edge entering RESP; read tracks the in-flight word every cycle
  always_ff @(posedge CLK) begin
    if (RST && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    mem_q <= mem[cur_idx];
  end

  // load extraction and extension; IO_IN is taken live so it is sampled in the RESP cycle
  always_comb begin
    src       = cap_mmio ? IO_IN : mem_q;
    byte_sh   = src >> {cap_addr[1:0], 3'b000};
    lane_b    = byte_sh[7:0];
    lane_h    = cap_addr[1] ? src[31:16] : src[15:0];
    rdata_now = src;
    case (cap_size)
      2'b00:   rdata_now = {{24{~cap_uns & lane_b[7]}}, lane_b};
      2'b01:   rdata_now = {{16{~cap_uns & lane_h[15]}}, lane_h};
      default: rdata_now = src;
    endcase
    if (cap_we || cap_err) rdata_now = 32'd0;
  end

  assign RSP_RDATA = (state == RESP) ? rdata_now : rdata_hold;

  // control FSM with registered handshake and IO outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      REQ_READY  <= 1'b1;
      RSP_VALID  <= 1'b0;
      RSP_ERR    <= 1'b0;
      IO_WR      <= 1'b0;
      IO_ADDR    <= 32'd0;
      IO_WDATA   <= 32'd0;
      rdata_hold <= 32'd0;
      cap_we     <= 1'b0;
      cap_uns    <= 1'b0;
      cap_err    <= 1'b0;
      cap_mmio   <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_size   <= 2'b00;
    end else begin
      IO_WR <= 1'b0;
      if (state == RESP) rdata_hold <= rdata_now;
      if (accept) begin
        cap_we    <= REQ_WE;
        cap_uns   <= REQ_UNSIGNED;
        cap_err   <= req_err;
        cap_mmio  <= req_mmio;
        cap_addr  <= REQ_ADDR;
        cap_wdata <= REQ_WDATA;
        cap_size  <= REQ_SIZE;
      end
      if (enter_resp) begin
        state     <= RESP;
        RSP_VALID <= 1'b1;
        RSP_ERR   <= cur_err;
        REQ_READY <= READY_IN_RESP;
        if (cur_we && cur_mmio && !cur_err) begin
          IO_WR    <= 1'b1;
          IO_ADDR  <= cur_addr;
          IO_WDATA <= cur_wdata;
        end
      end else if (accept) begin
        state     <= WAIT;
        cnt       <= WS;
        RSP_VALID <= 1'b0;
        REQ_READY <= 1'b0;
      end else if (state == WAIT) begin
        cnt       <= cnt - 4'd1;
        RSP_VALID <= 1'b0;
      end else begin
        state     <= IDLE;
        RSP_VALID <= 1'b0;
        REQ_READY <= 1'b1;
      end
    end
  end

endmodule
